// File: rtl/axi_stream_pkg.sv
// axi_stream_pkg
//   Shared definitions for the header-extraction stream block:
//   - state_t  : FSM states (length capture, first beat, body, flush)
//   - popcount : number of set bits in a byte-keep vector
//   - keep_msb : MSB-contiguous keep vector of a given byte count
//   Keep vectors are passed zero-extended to MAX_BYTES bits so one
//   function serves every stream width up to MAX_BYTES bytes per beat.
package axi_stream_pkg;

  typedef enum logic [1:0] {
    S_LEN   = 2'd0,
    S_FIRST = 2'd1,
    S_BODY  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam int MAX_BYTES = 64;

  function automatic int popcount(input logic [MAX_BYTES-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

  // Bits [nbytes-1 -: cnt] set: the first cnt bytes of an nbytes-wide
  // beat in MSB-first byte order.
  function automatic logic [MAX_BYTES-1:0] keep_msb(input int cnt, input int nbytes);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes && i >= nbytes - cnt) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// axis_byte_realign
//   Combinational byte realignment between the held residual and a new beat.
//   Ports:
//     i_data   : incoming beat, MSB-first bytes
//     i_keep   : byte keep of the incoming beat (cleared bytes are zeroed)
//     i_resid  : residual bytes of the previous beat, left-aligned, zero below
//     i_hlen   : header length in bytes (1..DATA_BYTE_WD)
//     o_tail   : top hlen bytes of the beat, right-aligned (header word, or
//                the part of the beat that completes the residual)
//     o_merged : residual followed by the top hlen bytes of the beat
//     o_resid  : remaining low bytes of the beat, left-aligned
module axis_byte_realign
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic [DATA_WD-1:0]      i_data,
  input  logic [DATA_BYTE_WD-1:0] i_keep,
  input  logic [DATA_WD-1:0]      i_resid,
  input  logic [CNT_WD-1:0]       i_hlen,
  output logic [DATA_WD-1:0]      o_tail,
  output logic [DATA_WD-1:0]      o_merged,
  output logic [DATA_WD-1:0]      o_resid
);

  logic [DATA_WD-1:0] w_masked;
  int                 w_tail_shift;
  int                 w_resid_shift;

  // Bytes with a cleared keep bit are forced to zero so that shifted-in
  // positions of short last beats never carry stale data.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
      assign w_masked[gi*8 +: 8] = i_keep[gi] ? i_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign w_tail_shift  = (DATA_BYTE_WD - int'(i_hlen)) * 8;
  assign w_resid_shift = int'(i_hlen) * 8;

  // A shift by the full width (hlen == DATA_BYTE_WD) yields zero, which is
  // exactly the empty residual of the pass-through case.
  assign o_tail   = w_masked >> w_tail_shift;
  assign o_merged = i_resid | o_tail;
  assign o_resid  = w_masked << w_resid_shift;

endmodule

// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
//   Strips a per-packet header of hlen bytes from the front of an AXI-Stream
//   packet and re-packs the remaining payload into full beats.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     valid_hlen/ready_hlen, hlen  : header length (bytes) for the next packet
//     valid_in/ready_in, data_in, keep_in, last_in : input stream
//     valid_header/ready_header, data_header, keep_header : extracted header,
//                                    right-aligned, keep = low hlen bits
//     valid_out/ready_out, data_out, keep_out, last_out   : payload stream
//   All outputs except ready_in/ready_hlen are registered.
module axi_stream_extract_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_hlen,
  output logic                    ready_hlen,
  input  logic [CNT_WD-1:0]       hlen,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_WD-1:0]       r_hlen;
  logic [DATA_WD-1:0]      r_resid;
  logic [CNT_WD-1:0]       r_resid_cnt;

  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;
  logic                    r_valid_header;
  logic [DATA_WD-1:0]      r_data_header;
  logic [DATA_BYTE_WD-1:0] r_keep_header;

  logic [DATA_WD-1:0]      w_tail;
  logic [DATA_WD-1:0]      w_merged;
  logic [DATA_WD-1:0]      w_resid_shift;
  logic [DATA_BYTE_WD-1:0] w_hdr_keep;
  int                      w_pc;
  int                      w_hlen;

  logic                    w_hdr_load;
  logic                    w_out_load;
  logic [DATA_WD-1:0]      w_out_data;
  logic [DATA_BYTE_WD-1:0] w_out_keep;
  logic                    w_out_last;
  logic                    w_resid_load;
  logic [CNT_WD-1:0]       w_resid_cnt_next;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_WD       (CNT_WD)
  ) u_realign (
    .i_data   (data_in),
    .i_keep   (keep_in),
    .i_resid  (r_resid),
    .i_hlen   (r_hlen),
    .o_tail   (w_tail),
    .o_merged (w_merged),
    .o_resid  (w_resid_shift)
  );

  assign w_pc   = popcount(MAX_BYTES'(keep_in));
  assign w_hlen = int'(r_hlen);
  // Header byte j lands at keep bit hlen-1-j; bytes the first beat did not
  // carry come out with their keep bit already cleared.
  assign w_hdr_keep = keep_in >> (DATA_BYTE_WD - w_hlen);

  always_comb begin
    w_state_next     = r_state;
    ready_in         = 1'b0;
    ready_hlen       = 1'b0;
    w_hdr_load       = 1'b0;
    w_out_load       = 1'b0;
    w_out_data       = '0;
    w_out_keep       = '0;
    w_out_last       = 1'b0;
    w_resid_load     = 1'b0;
    w_resid_cnt_next = '0;
    case (r_state)
      S_LEN: begin
        ready_hlen = 1'b1;
        if (valid_hlen) w_state_next = S_FIRST;
      end
      S_FIRST: begin
        // The header slot is single-entry; hold the packet until it drains.
        ready_in = !r_valid_header;
        if (valid_in && !r_valid_header) begin
          w_hdr_load   = 1'b1;
          w_resid_load = 1'b1;
          if (w_pc > w_hlen) w_resid_cnt_next = CNT_WD'(w_pc - w_hlen);
          if (!last_in)           w_state_next = S_BODY;
          else if (w_pc > w_hlen) w_state_next = S_FLUSH;
          else                    w_state_next = S_LEN;
        end
      end
      S_BODY: begin
        ready_in = !r_valid_out || ready_out;
        if (valid_in && (!r_valid_out || ready_out)) begin
          w_out_load   = 1'b1;
          w_out_data   = w_merged;
          w_resid_load = 1'b1;
          if (!last_in) begin
            w_out_keep       = '1;
            w_resid_cnt_next = CNT_WD'(DATA_BYTE_WD - w_hlen);
          end else if (w_pc <= w_hlen) begin
            // Residual plus the final bytes fit in one beat.
            w_out_keep   = DATA_BYTE_WD'(keep_msb(DATA_BYTE_WD - w_hlen + w_pc, DATA_BYTE_WD));
            w_out_last   = 1'b1;
            w_state_next = S_LEN;
          end else begin
            w_out_keep       = '1;
            w_resid_cnt_next = CNT_WD'(w_pc - w_hlen);
            w_state_next     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!r_valid_out || ready_out) begin
          w_out_load   = 1'b1;
          w_out_data   = r_resid;
          w_out_keep   = DATA_BYTE_WD'(keep_msb(int'(r_resid_cnt), DATA_BYTE_WD));
          w_out_last   = 1'b1;
          w_state_next = S_LEN;
        end
      end
      default: w_state_next = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_LEN;
      r_hlen         <= '0;
      r_resid        <= '0;
      r_resid_cnt    <= '0;
      r_valid_out    <= 1'b0;
      r_data_out     <= '0;
      r_keep_out     <= '0;
      r_last_out     <= 1'b0;
      r_valid_header <= 1'b0;
      r_data_header  <= '0;
      r_keep_header  <= '0;
    end else begin
      r_state <= w_state_next;
      if (valid_hlen && ready_hlen) r_hlen <= hlen;
      if (w_resid_load) begin
        r_resid     <= w_resid_shift;
        r_resid_cnt <= w_resid_cnt_next;
      end
      if (w_out_load) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_out_data;
        r_keep_out  <= w_out_keep;
        r_last_out  <= w_out_last;
      end else if (ready_out) begin
        r_valid_out <= 1'b0;
      end
      if (w_hdr_load) begin
        r_valid_header <= 1'b1;
        r_data_header  <= w_tail;
        r_keep_header  <= w_hdr_keep;
      end else if (ready_header) begin
        r_valid_header <= 1'b0;
      end
    end
  end

  assign valid_out    = r_valid_out;
  assign data_out     = r_data_out;
  assign keep_out     = r_keep_out;
  assign last_out     = r_last_out;
  assign valid_header = r_valid_header;
  assign data_header  = r_data_header;
  assign keep_header  = r_keep_header;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb_axi_stream_extract_header
//   Directed vectors with hand-computed expectations for the header
//   extractor at DATA_WD = 32. Inputs and ready signals change away from the
//   sampling edge; outputs are observed on the falling edge.
module tb_axi_stream_extract_header;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        valid_hlen;
  logic        ready_hlen;
  logic [2:0]  hlen;
  logic        valid_header;
  logic        ready_header = 1'b1;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;

  int errors = 0;
  int checks = 0;

  logic tog_en      = 1'b0;
  logic rdy_out_cfg = 1'b1;
  logic rdy_hdr_cfg = 1'b1;

  logic [36:0] act_out[$];
  logic [36:0] exp_out[$];
  logic [35:0] act_hdr[$];
  logic [35:0] exp_hdr[$];

  logic        out_stall = 1'b0;
  logic [37:0] out_prev  = '0;
  logic        hdr_stall = 1'b0;
  logic [36:0] hdr_prev  = '0;

  axi_stream_extract_header #(
    .DATA_WD      (32),
    .DATA_BYTE_WD (4),
    .CNT_WD       (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .valid_hlen   (valid_hlen),
    .ready_hlen   (ready_hlen),
    .hlen         (hlen),
    .valid_header (valid_header),
    .ready_header (ready_header),
    .data_header  (data_header),
    .keep_header  (keep_header),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ready signals change just after the rising edge so they are stable
  // whenever the falling-edge monitor and the drivers look at them.
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      ready_out    = !ready_out;
      ready_header = !ready_header;
    end else begin
      ready_out    = rdy_out_cfg;
      ready_header = rdy_hdr_cfg;
    end
  end

  // A handshake seen high on the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      out_stall <= 1'b0;
      hdr_stall <= 1'b0;
    end else begin
      if (out_stall)
        check("out_hold", 64'({valid_out, data_out, keep_out, last_out}), 64'(out_prev));
      if (hdr_stall)
        check("hdr_hold", 64'({valid_header, data_header, keep_header}), 64'(hdr_prev));
      if (valid_out && ready_out) act_out.push_back({data_out, keep_out, last_out});
      if (valid_header && ready_header) act_hdr.push_back({data_header, keep_header});
      out_stall <= valid_out && !ready_out;
      out_prev  <= {valid_out, data_out, keep_out, last_out};
      hdr_stall <= valid_header && !ready_header;
      hdr_prev  <= {valid_header, data_header, keep_header};
    end
  end

  task automatic send_hlen(input logic [2:0] h);
    int n;
    n = 0;
    valid_hlen = 1'b1;
    hlen       = h;
    while (!ready_hlen && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("hlen_timeout", 64'(0), 64'(1));
    @(negedge clk);
    valid_hlen = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_timeout", 64'(0), 64'(1));
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic exp_o(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_out.push_back({d, k, l});
  endtask

  task automatic exp_h(input logic [31:0] d, input logic [3:0] k);
    exp_hdr.push_back({d, k});
  endtask

  task automatic clear_all();
    act_out.delete();
    exp_out.delete();
    act_hdr.delete();
    exp_hdr.delete();
  endtask

  task automatic compare_all(input string name);
    repeat (20) @(negedge clk);
    check($sformatf("%s n_out", name), 64'(act_out.size()), 64'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < act_out.size(); i++)
      check($sformatf("%s out%0d", name, i), 64'(act_out[i]), 64'(exp_out[i]));
    check($sformatf("%s n_hdr", name), 64'(act_hdr.size()), 64'(exp_hdr.size()));
    for (int i = 0; i < exp_hdr.size() && i < act_hdr.size(); i++)
      check($sformatf("%s hdr%0d", name, i), 64'(act_hdr[i]), 64'(exp_hdr[i]));
    clear_all();
  endtask

  task automatic pkt_hlen3();
    send_hlen(3'd3);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2B3B4, 4'b1111, 1'b0);
    send_beat(32'hC1C2C3C4, 4'b1100, 1'b1);
    exp_h(32'h00A1A2A3, 4'b0111);
    exp_o(32'hA4B1B2B3, 4'b1111, 1'b0);
    exp_o(32'hB4C1C200, 4'b1110, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    data_in    = '0;
    keep_in    = '0;
    last_in    = 1'b0;
    valid_hlen = 1'b0;
    hlen       = '0;

    repeat (3) @(negedge clk);
    check("rst valid_out", 64'(valid_out), 64'(0));
    check("rst valid_header", 64'(valid_header), 64'(0));
    check("rst last_out", 64'(last_out), 64'(0));
    check("rst data_out", 64'({data_out, keep_out}), 64'(0));
    check("rst data_header", 64'({data_header, keep_header}), 64'(0));
    check("rst ready_in", 64'(ready_in), 64'(0));
    check("rst ready_hlen", 64'(ready_hlen), 64'(1));
    rst = 1'b0;
    @(negedge clk);

    // Three-beat packet, 3-byte header, short last beat.
    pkt_hlen3();
    compare_all("h3");

    // One-byte header; last beat overflows into a flush beat.
    send_hlen(3'd1);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h556677AA, 4'b1110, 1'b1);
    exp_h(32'h00000011, 4'b0001);
    exp_o(32'h22334455, 4'b1111, 1'b0);
    exp_o(32'h66770000, 4'b1100, 1'b1);
    compare_all("h1");

    // Full-width header: pass-through with one cycle of latency.
    send_hlen(3'd4);
    send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    check("lat valid_out", 64'(valid_out), 64'(1));
    check("lat data_out", 64'({data_out, keep_out, last_out}), 64'({32'h01020304, 4'b1111, 1'b0}));
    send_beat(32'h05060708, 4'b1111, 1'b1);
    check("lat last", 64'({valid_out, data_out, last_out}), 64'({1'b1, 32'h05060708, 1'b1}));
    exp_h(32'hDEADBEEF, 4'b1111);
    exp_o(32'h01020304, 4'b1111, 1'b0);
    exp_o(32'h05060708, 4'b1111, 1'b1);
    compare_all("h4");

    // Single-beat packets: residual flush, and no payload at all.
    send_hlen(3'd2);
    send_beat(32'h12345678, 4'b1111, 1'b1);
    exp_h(32'h00001234, 4'b0011);
    exp_o(32'h56780000, 4'b1100, 1'b1);
    send_hlen(3'd4);
    send_beat(32'hCAFEF00D, 4'b1111, 1'b1);
    exp_h(32'hCAFEF00D, 4'b1111);
    compare_all("single");

    // First beat shorter than the header: missing header byte gets keep cleared.
    send_hlen(3'd3);
    send_beat(32'h11223344, 4'b1100, 1'b1);
    exp_h(32'h00112200, 4'b0110);
    compare_all("short_hdr");

    // Undrained header blocks the next packet's first beat.
    rdy_hdr_cfg = 1'b0;
    repeat (2) @(negedge clk);
    send_hlen(3'd4);
    send_beat(32'h0A0B0C0D, 4'b1111, 1'b1);
    send_hlen(3'd4);
    @(negedge clk);
    check("hdr_block ready_in", 64'(ready_in), 64'(0));
    check("hdr_block valid_header", 64'(valid_header), 64'(1));
    rdy_hdr_cfg = 1'b1;
    send_beat(32'h0E0F1011, 4'b1111, 1'b1);
    exp_h(32'h0A0B0C0D, 4'b1111);
    exp_h(32'h0E0F1011, 4'b1111);
    compare_all("hdr_block");

    // Ten-beat packet of bytes 01..28 with both readies toggling.
    tog_en = 1'b1;
    send_hlen(3'd3);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'(4 * i + 1);
      send_beat({b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'b1111, i == 9);
    end
    exp_h(32'h00010203, 4'b0111);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] b;
      b = 8'(4 + 4 * k);
      exp_o({b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'b1111, 1'b0);
    end
    exp_o(32'h28000000, 4'b1000, 1'b1);
    compare_all("toggle");
    tog_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a packet with a payload beat pending.
    rdy_out_cfg = 1'b0;
    repeat (2) @(negedge clk);
    send_hlen(3'd2);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    check("pre_rst valid_out", 64'(valid_out), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst valid_out", 64'(valid_out), 64'(0));
    check("mid_rst valid_header", 64'(valid_header), 64'(0));
    check("mid_rst ready_hlen", 64'(ready_hlen), 64'(1));
    check("mid_rst ready_in", 64'(ready_in), 64'(0));
    rst = 1'b0;
    rdy_out_cfg = 1'b1;
    clear_all();
    repeat (3) @(negedge clk);
    pkt_hlen3();
    compare_all("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
